bcd2ascii: RTL and testbench
============================

BCD2ASCII -- requirements
Module: bcd2ascii

Interface
REQ-001 Parameter DEC_W, default 8: number of BCD digits accepted per conversion.
REQ-002 Parameter LZ_SUPPRESS, default 1: 1 skips leading zero digits; 0 emits all DEC_W digits.
REQ-003 Parameter TERM_EN, default 1: 1 appends a terminator byte after the last digit.
REQ-004 Parameter TERM_CHAR, default 8'h0A: terminator byte value.
REQ-005 clk  input  1  single clock; all state rising-edge triggered.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in  input  [DEC_W-1:0][3:0]  BCD digits; in[DEC_W-1] most significant; sampled only on accepted conv.
REQ-008 conv  input  1  start strobe; accepted only when rdy=1.
REQ-009 rdy  output  1  high only in IDLE.
REQ-010 err  output  1  one-cycle pulse: accepted conv contained a digit >9.
REQ-011 out_dat  output  8  ASCII byte.
REQ-012 out_val  output  1  out_dat valid.
REQ-013 out_rdy  input  1  downstream ready; byte transfers on out_val && out_rdy.
REQ-014 out_last  output  1  high with out_val on the final byte of the string.

Function
REQ-015 The block SHALL implement FSM states IDLE, SCAN, SEND, TERM.
REQ-016 IDLE: rdy=1, out_val=0; conv=1 with all digits <=9 SHALL register in, set idx=DEC_W-1, go to SCAN next cycle.
REQ-017 IDLE with conv=1 and any digit >9 SHALL pulse err for exactly the next cycle, stay IDLE, emit no bytes.
REQ-018 conv outside IDLE SHALL be ignored; the registered digits SHALL not change.
REQ-019 SCAN: one digit per cycle; if LZ_SUPPRESS=1, digit[idx]==0 and idx!=0 -> idx-1, stay SCAN; otherwise -> SEND.
REQ-020 Digit idx=0 SHALL never be suppressed; an all-zero input emits "0".
REQ-021 SEND: out_val=1, out_dat=8'h30+digit[idx] (4-bit digit zero-extended, 8-bit add).
REQ-022 SEND on handshake: idx>0 -> idx-1, stay SEND; idx==0 -> TERM if TERM_EN=1, else IDLE.
REQ-023 TERM: out_val=1, out_dat=TERM_CHAR; on handshake -> IDLE.
REQ-024 out_last SHALL be high in TERM, or in SEND at idx==0 when TERM_EN=0; low otherwise.
REQ-025 While out_val=1 and out_rdy=0, out_dat, out_last and state SHALL hold stable.
REQ-026 out_val SHALL not depend combinationally on out_rdy.
REQ-027 Latency: conv accepted at cycle N, k leading zeros skipped -> first out_val at N+2+k; with out_rdy held 1, one byte per cycle thereafter.
REQ-028 rdy SHALL return high the cycle after the final handshake; a new conv is then accepted, giving one idle cycle minimum between strings.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, rdy=1, out_val=0, out_last=0, err=0, out_dat=8'h00, idx=0, digit register=0.
REQ-030 Reset mid-string SHALL abort the string; after release no remaining byte (including terminator) is emitted.

Verification
REQ-031 DEC_W=4, defaults, in={7,2,1,3}, conv, out_rdy=1 -> bytes 37,32,31,33,0A on consecutive cycles, out_last on 0A, first out_val 2 cycles after conv.
REQ-032 DEC_W=4, in={0,0,4,5} -> 34,35,0A; first out_val 4 cycles after conv; with LZ_SUPPRESS=0 -> 30,30,34,35,0A.
REQ-033 DEC_W=4, in={0,0,0,0} -> 30,0A; TERM_EN=0 -> 30 alone with out_last=1.
REQ-034 in={0,A,0,0} -> err high one cycle, rdy stays 1, no out_val.
REQ-035 in={9,8,7,6}, out_rdy low 3 cycles on second byte -> 38 held stable 3 cycles, then 37,36,0A; no byte lost or duplicated.
REQ-036 rst pulsed while third byte is pending -> out_val low immediately; after release rdy=1, no further bytes, next conv converts normally.

Source files
------------

// File: rtl/bcd2ascii.sv
// Packed BCD digits to an ASCII byte stream, with optional leading-zero suppression and terminator.
// First byte 2+k cycles after conv (k = skipped zeros); each byte holds until out_val && out_rdy.
module bcd2ascii #(
  parameter int         DEC_W       = 8,
  parameter bit         LZ_SUPPRESS = 1'b1,
  parameter bit         TERM_EN     = 1'b1,
  parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEC_W-1:0][3:0] in,
  input  logic                  conv,
  output logic                  rdy,
  output logic                  err,
  output logic [7:0]            out_dat,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic                  out_last
);

  localparam int            IW      = (DEC_W > 1) ? $clog2(DEC_W) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DEC_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SEND, TERM} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [DEC_W-1:0][3:0]   dig;
  logic                    load;
  logic                    err_nxt;
  logic                    bad;
  logic [3:0]              cur;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DEC_W; i++) begin
      if (in[i] > 4'd9) bad = 1'b1;
    end
  end

  assign cur = dig[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      dig   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
      if (load) dig <= in;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (conv) begin
          if (bad) begin
            err_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            idx_nxt   = IDX_TOP;
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        // the units digit always goes out, so an all-zero value prints "0"
        if (LZ_SUPPRESS && (cur == 4'd0) && (idx != '0)) idx_nxt = idx - IW'(1);
        else                                              state_nxt = SEND;
      end
      SEND: begin
        if (out_rdy) begin
          if (idx != '0) idx_nxt = idx - IW'(1);
          else           state_nxt = TERM_EN ? TERM : IDLE;
        end
      end
      TERM: begin
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are decoded from registered state only, so they stay put while stalled
  always_comb begin
    out_dat = 8'h00;
    case (state)
      SEND:    out_dat = 8'h30 + {4'h0, cur};
      TERM:    out_dat = TERM_CHAR;
      default: out_dat = 8'h00;
    endcase
  end

  assign rdy      = (state == IDLE);
  assign out_val  = (state == SEND) || (state == TERM);
  assign out_last = (state == TERM) || ((state == SEND) && (idx == '0) && !TERM_EN);

endmodule

// File: tb/tb_bcd2ascii.sv
// Directed bench: three DEC_W=4 instances (defaults, no zero suppression, no terminator) share stimulus.
module tb_bcd2ascii;

  typedef struct packed {
    logic [31:0] c;
    logic [7:0]  d;
    logic        l;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0][3:0] in = '0;
  logic            conv = 1'b0;
  logic            out_rdy = 1'b1;

  logic       rdy_a, err_a, out_val_a, out_last_a;
  logic [7:0] out_dat_a;
  logic       rdy_b, err_b, out_val_b, out_last_b;
  logic [7:0] out_dat_b;
  logic       rdy_c, err_c, out_val_c, out_last_c;
  logic [7:0] out_dat_c;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   conv_cyc = 0;
  rec_t qa[$], qb[$], qc[$];
  int   eq[$], rq[$];
  logic [7:0] sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd2ascii #(.DEC_W(4)) u_a (
    .clk(clk), .rst(rst), .in(in), .conv(conv), .rdy(rdy_a), .err(err_a),
    .out_dat(out_dat_a), .out_val(out_val_a), .out_rdy(out_rdy), .out_last(out_last_a));
  bcd2ascii #(.DEC_W(4), .LZ_SUPPRESS(1'b0)) u_b (
    .clk(clk), .rst(rst), .in(in), .conv(conv), .rdy(rdy_b), .err(err_b),
    .out_dat(out_dat_b), .out_val(out_val_b), .out_rdy(out_rdy), .out_last(out_last_b));
  bcd2ascii #(.DEC_W(4), .TERM_EN(1'b0)) u_c (
    .clk(clk), .rst(rst), .in(in), .conv(conv), .rdy(rdy_c), .err(err_c),
    .out_dat(out_dat_c), .out_val(out_val_c), .out_rdy(out_rdy), .out_last(out_last_c));

  always @(negedge clk) begin
    if (out_val_a && out_rdy) qa.push_back('{c: cyc, d: out_dat_a, l: out_last_a});
    if (out_val_b && out_rdy) qb.push_back('{c: cyc, d: out_dat_b, l: out_last_b});
    if (out_val_c && out_rdy) qc.push_back('{c: cyc, d: out_dat_c, l: out_last_c});
    if (out_val_a && !out_rdy) sq.push_back(out_dat_a);
    if (err_a) eq.push_back(cyc);
    if (!rdy_a) rq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // caller is just after a rising edge; conv is held for exactly one cycle
  task automatic start(input logic [3:0][3:0] d);
    int t;
    t = 0;
    while (!rdy_a && t < 50) begin
      step(1);
      t++;
    end
    chk("start_rdy", {31'd0, rdy_a}, 32'd1);
    qa.delete(); qb.delete(); qc.delete();
    eq.delete(); rq.delete(); sq.delete();
    in       = d;
    conv     = 1'b1;
    conv_cyc = cyc;
    step(1);
    conv     = 1'b0;
  endtask

  // back-to-back string starting first_off cycles after conv
  task automatic check_str(input string tag, input rec_t q[$], input logic [7:0] e[8],
                           input int n, input int first_off);
    chk({tag, "_len"}, q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < q.size()) begin
        chk({tag, "_dat"}, {24'd0, q[i].d}, {24'd0, e[i]});
        chk({tag, "_last"}, {31'd0, q[i].l}, {31'd0, (i == n - 1)});
        chk({tag, "_cyc"}, q[i].c - conv_cyc, first_off + i);
      end
    end
  endtask

  initial begin
    int offs[5];
    logic [7:0] bp[5];

    step(3);
    chk("rst_a_flags", {28'd0, rdy_a, err_a, out_val_a, out_last_a}, 32'h8);
    chk("rst_a_dat", {24'd0, out_dat_a}, 32'h0);
    chk("rst_b_flags", {28'd0, rdy_b, err_b, out_val_b, out_last_b}, 32'h8);
    chk("rst_b_dat", {24'd0, out_dat_b}, 32'h0);
    chk("rst_c_flags", {28'd0, rdy_c, err_c, out_val_c, out_last_c}, 32'h8);
    chk("rst_c_dat", {24'd0, out_dat_c}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(2);

    start({4'd7, 4'd2, 4'd1, 4'd3});
    step(12);
    check_str("t1_a", qa, '{8'h37, 8'h32, 8'h31, 8'h33, 8'h0A, 8'h0, 8'h0, 8'h0}, 5, 2);
    check_str("t1_b", qb, '{8'h37, 8'h32, 8'h31, 8'h33, 8'h0A, 8'h0, 8'h0, 8'h0}, 5, 2);
    check_str("t1_c", qc, '{8'h37, 8'h32, 8'h31, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0}, 4, 2);

    start({4'd0, 4'd0, 4'd4, 4'd5});
    step(12);
    check_str("t2_a", qa, '{8'h34, 8'h35, 8'h0A, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3, 4);
    check_str("t2_b", qb, '{8'h30, 8'h30, 8'h34, 8'h35, 8'h0A, 8'h0, 8'h0, 8'h0}, 5, 2);
    check_str("t2_c", qc, '{8'h34, 8'h35, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2, 4);

    start({4'd0, 4'd0, 4'd0, 4'd0});
    step(12);
    check_str("t3_a", qa, '{8'h30, 8'h0A, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2, 5);
    check_str("t3_b", qb, '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0A, 8'h0, 8'h0, 8'h0}, 5, 2);
    check_str("t3_c", qc, '{8'h30, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1, 5);

    start({4'd0, 4'hA, 4'd0, 4'd0});
    step(8);
    chk("t4_err_cnt", eq.size(), 1);
    if (eq.size() > 0) chk("t4_err_cyc", eq[0] - conv_cyc, 1);
    chk("t4_rdy_low", rq.size(), 0);
    chk("t4_bytes", qa.size() + qb.size() + qc.size(), 0);

    start({4'd9, 4'd8, 4'd7, 4'd6});
    step(2);
    out_rdy = 1'b0;
    step(3);
    out_rdy = 1'b1;
    step(10);
    offs = '{2, 6, 7, 8, 9};
    bp   = '{8'h39, 8'h38, 8'h37, 8'h36, 8'h0A};
    chk("t5_len", qa.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < qa.size()) begin
        chk("t5_dat", {24'd0, qa[i].d}, {24'd0, bp[i]});
        chk("t5_cyc", qa[i].c - conv_cyc, offs[i]);
        chk("t5_last", {31'd0, qa[i].l}, {31'd0, (i == 4)});
      end
    end
    chk("t5_stall_len", sq.size(), 3);
    foreach (sq[i]) chk("t5_stall_dat", {24'd0, sq[i]}, 32'h38);

    start({4'd1, 4'd2, 4'd3, 4'd4});
    step(3);
    out_rdy = 1'b0;
    chk("t6_pend_val", {31'd0, out_val_a}, 32'd1);
    chk("t6_pend_dat", {24'd0, out_dat_a}, 32'h33);
    rst = 1'b1;
    #1;
    chk("t6_rst_val", {31'd0, out_val_a}, 32'd0);
    chk("t6_rst_rdy", {31'd0, rdy_a}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_rdy = 1'b1;
    step(10);
    chk("t6_bytes", qa.size(), 2);
    chk("t6_rdy", {31'd0, rdy_a}, 32'd1);
    start({4'd0, 4'd0, 4'd0, 4'd7});
    step(12);
    check_str("t6_a", qa, '{8'h37, 8'h0A, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule
